fifo_sync_ctrl: RTL and testbench



---
 rtl/fifo_sync_ctrl_if.sv | 29 ++
 rtl/fifo_sync_ctrl.sv | 91 +++++++++
 tb/tb_fifo_sync_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_ctrl_if.sv
// User-side bundle of the synchronous FIFO controller: request/data inputs, read data,
// data-valid strobe, occupancy count and status flags.
interface fifo_sync_ctrl_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 7
);
    logic              WE;
    logic [WIDTH-1:0]  DATA;
    logic              RE;
    logic [WIDTH-1:0]  Q;
    logic              DVLD;
    logic              FULL;
    logic              EMPTY;
    logic              AFULL;
    logic              AEMPTY;
    logic [ADDR_W:0]   WRCNT;
    logic              OVERFLOW;
    logic              UNDERFLOW;

    modport master (
        output WE, DATA, RE,
        input  Q, DVLD, FULL, EMPTY, AFULL, AEMPTY, WRCNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  WE, DATA, RE,
        output Q, DVLD, FULL, EMPTY, AFULL, AEMPTY, WRCNT, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller driving an external dual-port RAM: pointers, occupancy,
// registered status flags, error pulses and a read-latency-matched data-valid strobe.
module fifo_sync_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned AF_THRESH = 120,
    parameter int unsigned AE_THRESH = 8,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    fifo_sync_ctrl_if.slave   usr,
    output logic [WIDTH-1:0]  MEM_WDATA,
    output logic [ADDR_W-1:0] MEM_WADDR,
    output logic              MEM_WEN,
    output logic [ADDR_W-1:0] MEM_RADDR,
    output logic              MEM_REN,
    input  logic [WIDTH-1:0]  MEM_RDATA
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, empty_q, afull_q, aempty_q;
    logic              overflow_q, underflow_q;
    logic [RD_LAT-1:0] dvld_sr_q;
    logic              wa, ra;

    // Acceptance uses only the registered flags, so a simultaneous opposite
    // request never rescues a write at full or a read at empty.
    assign wa = usr.WE & ~full_q;
    assign ra = usr.RE & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({wa, ra})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dvld_sr_q   <= '0;
        end else begin
            if (wa) wptr_q <= wptr_q + 1'b1;
            if (ra) rptr_q <= rptr_q + 1'b1;
            count_q     <= count_d;
            // Flags follow the next count so they line up with WRCNT.
            full_q      <= (count_d == CNT_W'(DEPTH));
            empty_q     <= (count_d == '0);
            afull_q     <= (count_d >= CNT_W'(AF_THRESH));
            aempty_q    <= (count_d <= CNT_W'(AE_THRESH));
            overflow_q  <= usr.WE & full_q;
            underflow_q <= usr.RE & empty_q;
            dvld_sr_q[0] <= ra;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                dvld_sr_q[i] <= dvld_sr_q[i-1];
            end
        end
    end

    assign MEM_WEN   = wa;
    assign MEM_WADDR = wptr_q;
    assign MEM_WDATA = usr.DATA;
    assign MEM_REN   = ra;
    assign MEM_RADDR = rptr_q;

    assign usr.Q         = MEM_RDATA;
    assign usr.DVLD      = dvld_sr_q[RD_LAT-1];
    assign usr.FULL      = full_q;
    assign usr.EMPTY     = empty_q;
    assign usr.AFULL     = afull_q;
    assign usr.AEMPTY    = aempty_q;
    assign usr.WRCNT     = count_q;
    assign usr.OVERFLOW  = overflow_q;
    assign usr.UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl: two instances (read latency 1 and 2) share one stimulus stream,
// each with a behavioural RAM; a scoreboard checks read data order and DVLD timing.
module tb_fifo_sync_ctrl;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 7;
    localparam int          DEPTH  = 128;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic        re  = 1'b0;
    logic [31:0] data = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errs = 0;

    logic [WIDTH-1:0]  m_wdata [2];
    logic [ADDR_W-1:0] m_waddr [2];
    logic              m_wen   [2];
    logic [ADDR_W-1:0] m_raddr [2];
    logic              m_ren   [2];
    logic [WIDTH-1:0]  m_rdata [2];

    logic [31:0] mdl_q[$];
    exp_t        exp0[$];
    exp_t        exp1[$];
    int          m_cnt = 0;
    logic [6:0]  m_wptr = '0;
    logic [6:0]  m_rptr = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_sync_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u1 ();
    fifo_sync_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u2 ();

    assign u1.WE = we;
    assign u1.RE = re;
    assign u1.DATA = data;
    assign u2.WE = we;
    assign u2.RE = re;
    assign u2.DATA = data;

    fifo_sync_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AF_THRESH(120), .AE_THRESH(8),
                     .RD_LAT(1)) dut1 (
        .CLOCK(clk), .RESET(rst), .usr(u1),
        .MEM_WDATA(m_wdata[0]), .MEM_WADDR(m_waddr[0]), .MEM_WEN(m_wen[0]),
        .MEM_RADDR(m_raddr[0]), .MEM_REN(m_ren[0]), .MEM_RDATA(m_rdata[0])
    );

    fifo_sync_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AF_THRESH(120), .AE_THRESH(8),
                     .RD_LAT(2)) dut2 (
        .CLOCK(clk), .RESET(rst), .usr(u2),
        .MEM_WDATA(m_wdata[1]), .MEM_WADDR(m_waddr[1]), .MEM_WEN(m_wen[1]),
        .MEM_RADDR(m_raddr[1]), .MEM_REN(m_ren[1]), .MEM_RDATA(m_rdata[1])
    );

    // Behavioural RAMs: write on the edge, registered read, optional output stage.
    for (genvar g = 0; g < 2; g++) begin : g_ram
        logic [31:0] mem [128];
        logic [31:0] rd1, rd2;
        always @(posedge clk) begin
            if (m_wen[g]) mem[m_waddr[g]] <= m_wdata[g];
            if (m_ren[g]) rd1 <= mem[m_raddr[g]];
            rd2 <= rd1;
        end
        assign m_rdata[g] = (g == 0) ? rd1 : rd2;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input logic [31:0] q);
        exp_t e;
        if ((d == 0 && exp0.size() == 0) || (d == 1 && exp1.size() == 0)) begin
            n_checks++;
            n_errs++;
            $display("FAIL dvld_unexpected dut%0d: got DVLD=1 Q=%0h expected DVLD=0 (cycle %0d)",
                     d + 1, q, cyc);
            return;
        end
        e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
        check($sformatf("rdata_dut%0d", d + 1), {q, 32'(cyc)}, {e.data, e.cyc});
    endtask

    always @(negedge clk) begin
        if (u1.DVLD === 1'b1) mon(0, u1.Q);
        if (u2.DVLD === 1'b1) mon(1, u2.Q);
    end

    task automatic check_state(input string name, input bit ovf, input bit unf);
        logic [13:0] exp;
        exp = {8'(m_cnt), m_cnt == DEPTH, m_cnt == 0, m_cnt >= 120, m_cnt <= 8, ovf, unf};
        check({name, "_dut1"}, 64'({u1.WRCNT, u1.FULL, u1.EMPTY, u1.AFULL, u1.AEMPTY,
                                    u1.OVERFLOW, u1.UNDERFLOW}), 64'(exp));
        check({name, "_dut2"}, 64'({u2.WRCNT, u2.FULL, u2.EMPTY, u2.AFULL, u2.AEMPTY,
                                    u2.OVERFLOW, u2.UNDERFLOW}), 64'(exp));
    endtask

    task automatic drive(input bit w, input bit r, input logic [31:0] d);
        bit pf, pe, ewa, era;
        exp_t e;
        we = w;
        re = r;
        data = d;
        pf = (m_cnt == DEPTH);
        pe = (m_cnt == 0);
        ewa = w && !pf;
        era = r && !pe;
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("mem_drive_dut%0d", g + 1),
                  {15'd0, m_wen[g], m_ren[g], m_waddr[g], m_raddr[g], m_wdata[g]},
                  {15'd0, ewa, era, m_wptr, m_rptr, d});
        end
        if (era) begin
            e.data = mdl_q.pop_front();
            e.cyc = 32'(cyc + 1);
            exp0.push_back(e);
            e.cyc = 32'(cyc + 2);
            exp1.push_back(e);
            m_rptr = m_rptr + 1'b1;
            m_cnt--;
        end
        if (ewa) begin
            mdl_q.push_back(d);
            m_wptr = m_wptr + 1'b1;
            m_cnt++;
        end
        @(posedge clk);
        #1;
        check_state("state", w && pf, r && pe);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset(input int left1, input int left2);
        we = 1'b0;
        re = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("pending_at_reset", 64'({exp0.size(), exp1.size()}), 64'({left1, left2}));
        exp0.delete();
        exp1.delete();
        mdl_q.delete();
        m_cnt = 0;
        m_wptr = '0;
        m_rptr = '0;
        check_state("reset", 1'b0, 1'b0);
        check("reset_dvld", 64'({u1.DVLD, u2.DVLD}), 64'd0);
    endtask

    initial begin
        do_reset(0, 0);
        // Fill to full, then one rejected write.
        for (int i = 0; i < 128; i++) drive(1'b1, 1'b0, 32'(i));
        drive(1'b1, 1'b0, 32'hDEAD_BEEF);
        // Drain completely, then one rejected read.
        for (int i = 0; i < 128; i++) drive(1'b0, 1'b1, 32'd0);
        drive(1'b0, 1'b1, 32'd0);
        idle(4);
        // Simultaneous read/write at steady occupancy.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 32'h200 + 32'(i));
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 32'h300 + 32'(i));
        // Boundaries: both requests at empty, then at full.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 32'd0);
        drive(1'b1, 1'b1, 32'h400);
        for (int i = 0; i < 127; i++) drive(1'b1, 1'b0, 32'h500 + 32'(i));
        drive(1'b1, 1'b1, 32'h600);
        for (int i = 0; i < 127; i++) drive(1'b0, 1'b1, 32'd0);
        idle(4);
        // Write then read of the same location on the next cycle.
        drive(1'b1, 1'b0, 32'hA5A5_A5A5);
        drive(1'b0, 1'b1, 32'd0);
        idle(4);
        // Pointer wrap.
        do_reset(0, 0);
        for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 32'h1000 + 32'(i));
        for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 60; i++) drive(1'b1, 1'b0, 32'h2000 + 32'(i));
        for (int i = 0; i < 60; i++) drive(1'b0, 1'b1, 32'd0);
        idle(4);
        // Reset with reads in flight: the last latency-2 read must never surface.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 32'h3000 + 32'(i));
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'd0);
        do_reset(0, 1);
        idle(6);
        check("final_pending", 64'({exp0.size(), exp1.size()}), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
